// File: rtl/iram_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// iram_access_ctrl_pkg
//   Shared constants and types for the instruction-RAM access controller.
//   ADDR_W   : word address width of the instruction RAM
//   INSTR_W  : instruction word width
//   RESET_PC : first instruction address fetched after reset
//   mode_e   : controller operating modes (RUN / DRAIN / LOAD / EXIT)
//   rr_ptr_e : round-robin priority pointer (which requester wins a tie)
// -----------------------------------------------------------------------------
package iram_access_ctrl_pkg;

  localparam int ADDR_W  = 11;
  localparam int INSTR_W = 33;

  localparam logic [ADDR_W-1:0] RESET_PC = 11'd1024;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_DRAIN = 2'd1,
    MODE_LOAD  = 2'd2,
    MODE_EXIT  = 2'd3
  } mode_e;

  typedef enum logic {
    RR_FETCH  = 1'b0,
    RR_LOADER = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/iram_access_ctrl_rr_arb.sv
// -----------------------------------------------------------------------------
// iram_rr_arb
//   Two-requester round-robin arbiter (fetch vs loader) for the instruction RAM.
//   A requester is offered ready whenever it is allowed and either the other
//   side is not competing or the pointer gives it priority. The pointer moves
//   to the other requester after every grant.
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     allow_f/allow_l : requester may be served in the current mode
//     req_f/req_l     : request valids
//     rdy_f/rdy_l     : ready offered to each requester (combinational)
//     gnt_f/gnt_l     : request accepted this cycle (valid & ready)
// -----------------------------------------------------------------------------
module iram_rr_arb
  import iram_access_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic allow_f,
  input  logic allow_l,
  input  logic req_f,
  input  logic req_l,
  output logic rdy_f,
  output logic rdy_l,
  output logic gnt_f,
  output logic gnt_l
);

  rr_ptr_e ptr;
  logic    cand_f;
  logic    cand_l;

  assign cand_f = allow_f & req_f;
  assign cand_l = allow_l & req_l;

  // Both readies may be high when there is no contention; when both compete
  // exactly one ready is raised, so at most one grant happens per cycle.
  always_comb begin
    rdy_f = allow_f & (~cand_l | (ptr == RR_FETCH));
    rdy_l = allow_l & (~cand_f | (ptr == RR_LOADER));
  end

  assign gnt_f = rdy_f & req_f;
  assign gnt_l = rdy_l & req_l;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= RR_FETCH;
    end else if (gnt_f) begin
      ptr <= RR_LOADER;
    end else if (gnt_l) begin
      ptr <= RR_FETCH;
    end
  end

endmodule

// File: rtl/iram_access_ctrl.sv
// -----------------------------------------------------------------------------
// iram_access_ctrl
//   Sequences all accesses to the single-port, synchronous-read instruction
//   RAM. Fetch reads and loader writes share the port through a round-robin
//   arbiter; a program mode drains in-flight reads and gives the loader
//   exclusive access.
//   Ports:
//     clk, rst_n                         : clock, asynchronous active-low reset
//     fetch_req_valid/ready, fetch_addr  : fetch read request handshake
//     fetch_flush                        : drop every in-flight read response
//     fetch_rvalid, fetch_rdata          : read response (no backpressure)
//     ld_req_valid/ready, ld_addr/wdata  : loader write request handshake
//     ld_wack                            : pulse when a write reached the RAM
//     prog_mode_req / prog_mode_ack      : exclusive loader mode request/status
//     iram_addr/rnw/wdata/drive_en       : registered RAM-side controls
//     iram_rdata                         : RAM read data
// -----------------------------------------------------------------------------
module iram_access_ctrl
  import iram_access_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_req_valid,
  output logic               fetch_req_ready,
  input  logic [ADDR_W-1:0]  fetch_addr,
  input  logic               fetch_flush,
  output logic               fetch_rvalid,
  output logic [INSTR_W-1:0] fetch_rdata,
  input  logic               ld_req_valid,
  output logic               ld_req_ready,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic [INSTR_W-1:0] ld_wdata,
  output logic               ld_wack,
  input  logic               prog_mode_req,
  output logic               prog_mode_ack,
  output logic [ADDR_W-1:0]  iram_addr,
  output logic               iram_rnw,
  output logic [INSTR_W-1:0] iram_wdata,
  output logic               iram_drive_en,
  input  logic [INSTR_W-1:0] iram_rdata
);

  mode_e mode;
  mode_e mode_nxt;

  logic allow_f;
  logic allow_l;
  logic gnt_f;
  logic gnt_l;

  logic rd_tag_p0;
  logic rd_tag_p1;
  logic wr_pend_p0;
  logic wack_p1;
  logic rd_inflight;
  logic wr_pending;

  // Readies are forced low while reset is asserted so nothing is accepted
  // before the controller state is valid.
  assign allow_f = rst_n & (mode == MODE_RUN);
  assign allow_l = rst_n & ((mode == MODE_RUN) | (mode == MODE_LOAD));

  iram_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .allow_f (allow_f),
    .allow_l (allow_l),
    .req_f   (fetch_req_valid),
    .req_l   (ld_req_valid),
    .rdy_f   (fetch_req_ready),
    .rdy_l   (ld_req_ready),
    .gnt_f   (gnt_f),
    .gnt_l   (gnt_l)
  );

  assign rd_inflight = rd_tag_p0 | rd_tag_p1;
  // A write counts as pending until its acknowledge has been presented.
  assign wr_pending  = wr_pend_p0 | wack_p1;

  // Mode FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= MODE_RUN;
    end else begin
      mode <= mode_nxt;
    end
  end

  always_comb begin
    mode_nxt = mode;
    case (mode)
      MODE_RUN: begin
        if (prog_mode_req) mode_nxt = MODE_DRAIN;
      end
      MODE_DRAIN: begin
        if (!prog_mode_req) begin
          mode_nxt = MODE_RUN;
        end else if (!rd_inflight && !wr_pending) begin
          mode_nxt = MODE_LOAD;
        end
      end
      MODE_LOAD: begin
        if (!prog_mode_req) mode_nxt = MODE_EXIT;
      end
      MODE_EXIT: begin
        if (!wr_pending) mode_nxt = MODE_RUN;
      end
      default: mode_nxt = MODE_RUN;
    endcase
  end

  assign prog_mode_ack = (mode == MODE_LOAD);

  // Stage p0: request accepted, RAM command registered.
  // Stage p1: RAM has sampled the command; read data / write ack presented.
  // A flush kills the accepting read and both tag stages in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_tag_p0  <= 1'b0;
      rd_tag_p1  <= 1'b0;
      wr_pend_p0 <= 1'b0;
      wack_p1    <= 1'b0;
    end else begin
      rd_tag_p0  <= gnt_f & ~fetch_flush;
      rd_tag_p1  <= rd_tag_p0 & ~fetch_flush;
      wr_pend_p0 <= gnt_l;
      wack_p1    <= wr_pend_p0;
    end
  end

  // The response due in the flush cycle itself is suppressed as well.
  assign fetch_rvalid = rd_tag_p1 & ~fetch_flush;
  assign fetch_rdata  = iram_rdata;
  assign ld_wack      = wack_p1;

  // Stage p0: RAM-side command register. Address holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iram_addr     <= '0;
      iram_wdata    <= '0;
      iram_rnw      <= 1'b1;
      iram_drive_en <= 1'b0;
    end else if (gnt_l) begin
      iram_addr     <= ld_addr;
      iram_wdata    <= ld_wdata;
      iram_rnw      <= 1'b0;
      iram_drive_en <= 1'b1;
    end else begin
      iram_rnw      <= 1'b1;
      iram_drive_en <= 1'b0;
      if (gnt_f) iram_addr <= fetch_addr;
    end
  end

endmodule
